// File: rtl/vxe_mem_defs.sv
// rtl/vxe_mem_defs.sv - VxE memory channel field layout shared with client LSUs
package vxe_mem_defs;

  localparam int DATA_W  = 64;
  localparam int BEN_W   = 8;
  localparam int ADDR_W  = 37;
  localparam int TXNID_W = 6;
  localparam int RQA_W   = 1 + TXNID_W + ADDR_W;
  localparam int RQD_W   = BEN_W + DATA_W;
  localparam int RSS_W   = TXNID_W + 3;

  localparam logic RNW_READ = 1'b1;

  // Packed field order is the wire order: msb first.
  typedef struct packed {
    logic               rnw;
    logic [TXNID_W-1:0] txnid;
    logic [ADDR_W-1:0]  addr;
  } rqa_t;

  typedef struct packed {
    logic [BEN_W-1:0]  ben;
    logic [DATA_W-1:0] data;
  } rqd_t;

  typedef struct packed {
    logic [TXNID_W-1:0] txnid;
    logic               rnw;
    logic               err;
    logic               rsvd;
  } rss_t;

  function automatic rss_t make_rss(input logic [TXNID_W-1:0] txnid,
                                    input logic rnw, input logic err);
    rss_t r;
    r.txnid = txnid;
    r.rnw   = rnw;
    r.err   = err;
    r.rsvd  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/vxe_mem_rsp_fifo.sv
// rtl/vxe_mem_rsp_fifo.sv - show-ahead synchronous FIFO with full/empty and free-entry count
module vxe_mem_rsp_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_POW2 = 2
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  i_push,
  input  logic [WIDTH-1:0]      i_data,
  input  logic                  i_pop,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_POW2:0]   o_free
);

  localparam int DEPTH = 1 << DEPTH_POW2;
  localparam logic [DEPTH_POW2:0] DEPTH_L = {1'b1, {DEPTH_POW2{1'b0}}};
  localparam logic [DEPTH_POW2:0] PTR_ONE = {{DEPTH_POW2{1'b0}}, 1'b1};

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_POW2:0] r_wr_ptr;
  logic [DEPTH_POW2:0] r_rd_ptr;
  logic [DEPTH_POW2:0] w_count;
  logic                w_push;
  logic                w_pop;

  // Pointers carry one wrap bit so count==DEPTH is distinguishable from empty.
  assign w_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (w_count == DEPTH_L);
  assign o_empty = (w_count == '0);
  assign o_free  = DEPTH_L - w_count;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr[DEPTH_POW2-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[DEPTH_POW2-1:0]] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/vxe_mem_rsp_sram.sv
// rtl/vxe_mem_rsp_sram.sv - SRAM-backed in-order VxE memory responder
module vxe_mem_rsp_sram
  import vxe_mem_defs::*;
#(
  parameter int MEM_POW2      = 12,
  parameter int RQ_DEPTH_POW2 = 2,
  parameter int RS_DEPTH_POW2 = 2
) (
  input  logic              clk,
  input  logic              nrst,
  output logic              o_rqa_rdy,
  input  logic [RQA_W-1:0]  i_rqa,
  input  logic              i_rqa_wr,
  output logic              o_rqd_rdy,
  input  logic [RQD_W-1:0]  i_rqd,
  input  logic              i_rqd_wr,
  output logic              o_rss_vld,
  output logic [RSS_W-1:0]  o_rss,
  input  logic              i_rss_rd,
  output logic              o_rsd_vld,
  output logic [DATA_W-1:0] o_rsd,
  input  logic              i_rsd_rd
);

  localparam logic [RS_DEPTH_POW2:0] RESV_ONE = {{RS_DEPTH_POW2{1'b0}}, 1'b1};

  rqa_t                   w_rqa_head;
  rqd_t                   w_rqd_head;
  logic                   w_rqa_full, w_rqa_empty;
  logic                   w_rqd_full, w_rqd_empty;
  logic                   w_rss_full, w_rss_empty;
  logic                   w_rsd_full, w_rsd_empty;
  logic [RQ_DEPTH_POW2:0] w_rqa_free, w_rqd_free;
  logic [RS_DEPTH_POW2:0] w_rss_free, w_rsd_free;

  logic                   w_addr_err;
  logic                   w_rss_space, w_rsd_space;
  logic                   w_issue_rd, w_issue_wr, w_issue;
  logic [MEM_POW2-1:0]    w_idx;

  logic [DATA_W-1:0]      r_mem [0:(1<<MEM_POW2)-1];
  logic [DATA_W-1:0]      r_rdata;

  logic                   r_wb_vld;
  logic                   r_wb_rnw;
  logic                   r_wb_err;
  logic [TXNID_W-1:0]     r_wb_txnid;
  logic [RS_DEPTH_POW2:0] r_rss_resv, r_rsd_resv;
  logic [RS_DEPTH_POW2:0] w_rss_resv_nxt, w_rsd_resv_nxt;

  rss_t                   w_rss_wdata;
  logic [DATA_W-1:0]      w_rsd_wdata;
  logic                   w_unused_ok;

  vxe_mem_rsp_fifo #(.WIDTH(RQA_W), .DEPTH_POW2(RQ_DEPTH_POW2)) u_rqa_fifo (
    .clk(clk), .nrst(nrst),
    .i_push(i_rqa_wr), .i_data(i_rqa), .i_pop(w_issue),
    .o_data(w_rqa_head), .o_full(w_rqa_full), .o_empty(w_rqa_empty), .o_free(w_rqa_free)
  );

  vxe_mem_rsp_fifo #(.WIDTH(RQD_W), .DEPTH_POW2(RQ_DEPTH_POW2)) u_rqd_fifo (
    .clk(clk), .nrst(nrst),
    .i_push(i_rqd_wr), .i_data(i_rqd), .i_pop(w_issue_wr),
    .o_data(w_rqd_head), .o_full(w_rqd_full), .o_empty(w_rqd_empty), .o_free(w_rqd_free)
  );

  vxe_mem_rsp_fifo #(.WIDTH(RSS_W), .DEPTH_POW2(RS_DEPTH_POW2)) u_rss_fifo (
    .clk(clk), .nrst(nrst),
    .i_push(r_wb_vld), .i_data(w_rss_wdata), .i_pop(i_rss_rd),
    .o_data(o_rss), .o_full(w_rss_full), .o_empty(w_rss_empty), .o_free(w_rss_free)
  );

  vxe_mem_rsp_fifo #(.WIDTH(DATA_W), .DEPTH_POW2(RS_DEPTH_POW2)) u_rsd_fifo (
    .clk(clk), .nrst(nrst),
    .i_push(r_wb_vld && r_wb_rnw), .i_data(w_rsd_wdata), .i_pop(i_rsd_rd),
    .o_data(o_rsd), .o_full(w_rsd_full), .o_empty(w_rsd_empty), .o_free(w_rsd_free)
  );

  assign o_rqa_rdy = !w_rqa_full;
  assign o_rqd_rdy = !w_rqd_full;
  assign o_rss_vld = !w_rss_empty;
  assign o_rsd_vld = !w_rsd_empty;

  // Reservations never let writeback hit a full response FIFO, so these are spare.
  assign w_unused_ok = &{1'b0, w_rqa_free, w_rqd_free, w_rss_full, w_rsd_full};

  assign w_addr_err  = |(w_rqa_head.addr >> MEM_POW2);
  assign w_idx       = w_rqa_head.addr[MEM_POW2-1:0];
  assign w_rss_space = (w_rss_free > r_rss_resv);
  assign w_rsd_space = (w_rsd_free > r_rsd_resv);

  always_comb begin
    w_issue_rd = 1'b0;
    w_issue_wr = 1'b0;
    if (!w_rqa_empty) begin
      if (w_rqa_head.rnw == RNW_READ) begin
        w_issue_rd = w_rss_space && w_rsd_space;
      end else begin
        w_issue_wr = w_rss_space && !w_rqd_empty;
      end
    end
    w_issue = w_issue_rd || w_issue_wr;
  end

  // Single-port SRAM: one access per cycle, byte-enabled writes.
  always_ff @(posedge clk) begin
    if (w_issue && !w_addr_err) begin
      if (w_issue_wr) begin
        for (int b = 0; b < BEN_W; b++) begin
          if (w_rqd_head.ben[b]) r_mem[w_idx][8*b +: 8] <= w_rqd_head.data[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[w_idx];
      end
    end
  end

  // Issue reserves an entry; writeback converts it into an occupied entry.
  always_comb begin
    w_rss_resv_nxt = r_rss_resv;
    w_rsd_resv_nxt = r_rsd_resv;
    if (w_issue && !r_wb_vld) begin
      w_rss_resv_nxt = r_rss_resv + RESV_ONE;
    end else if (!w_issue && r_wb_vld) begin
      w_rss_resv_nxt = r_rss_resv - RESV_ONE;
    end
    if (w_issue_rd && !(r_wb_vld && r_wb_rnw)) begin
      w_rsd_resv_nxt = r_rsd_resv + RESV_ONE;
    end else if (!w_issue_rd && r_wb_vld && r_wb_rnw) begin
      w_rsd_resv_nxt = r_rsd_resv - RESV_ONE;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wb_vld   <= 1'b0;
      r_wb_rnw   <= 1'b0;
      r_wb_err   <= 1'b0;
      r_wb_txnid <= '0;
      r_rss_resv <= '0;
      r_rsd_resv <= '0;
    end else begin
      r_wb_vld   <= w_issue;
      r_rss_resv <= w_rss_resv_nxt;
      r_rsd_resv <= w_rsd_resv_nxt;
      if (w_issue) begin
        r_wb_rnw   <= w_rqa_head.rnw;
        r_wb_err   <= w_addr_err;
        r_wb_txnid <= w_rqa_head.txnid;
      end
    end
  end

  assign w_rss_wdata = make_rss(r_wb_txnid, r_wb_rnw, r_wb_err);
  assign w_rsd_wdata = r_wb_err ? '0 : r_rdata;

endmodule

// File: tb/tb_vxe_mem_rsp_sram.sv
// tb/tb_vxe_mem_rsp_sram.sv - directed self-checking bench for vxe_mem_rsp_sram
module tb_vxe_mem_rsp_sram;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        o_rqa_rdy, o_rqd_rdy, o_rss_vld, o_rsd_vld;
  logic [43:0] i_rqa = '0;
  logic        i_rqa_wr = 1'b0;
  logic [71:0] i_rqd = '0;
  logic        i_rqd_wr = 1'b0;
  logic [8:0]  o_rss;
  logic        i_rss_rd = 1'b0;
  logic [63:0] o_rsd;
  logic        i_rsd_rd = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0]  rss_q[$];
  logic [63:0] rsd_q[$];
  logic [63:0] bp_data [20];

  vxe_mem_rsp_sram #(.MEM_POW2(12), .RQ_DEPTH_POW2(2), .RS_DEPTH_POW2(2)) dut (
    .clk(clk), .nrst(nrst),
    .o_rqa_rdy(o_rqa_rdy), .i_rqa(i_rqa), .i_rqa_wr(i_rqa_wr),
    .o_rqd_rdy(o_rqd_rdy), .i_rqd(i_rqd), .i_rqd_wr(i_rqd_wr),
    .o_rss_vld(o_rss_vld), .o_rss(o_rss), .i_rss_rd(i_rss_rd),
    .o_rsd_vld(o_rsd_vld), .o_rsd(o_rsd), .i_rsd_rd(i_rsd_rd)
  );

  always #5 clk = ~clk;

  // Record every popped response; inputs change #1 after posedge, so negedge is stable.
  always @(negedge clk) begin
    if (nrst && o_rss_vld && i_rss_rd) rss_q.push_back(o_rss);
    if (nrst && o_rsd_vld && i_rsd_rd) rsd_q.push_back(o_rsd);
  end

  function automatic logic [8:0] rss_exp(input logic [5:0] txn, input logic rnw, input logic err);
    return {txn, rnw, err, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rqa(input logic rnw, input logic [5:0] txn, input logic [36:0] addr);
    int n = 0;
    while (!o_rqa_rdy && n < 200) begin
      tick();
      n++;
    end
    n_vec++;
    if (!o_rqa_rdy) begin
      n_err++;
      $display("FAIL rqa_push_wait: o_rqa_rdy=%b required 1 within 200 cycles", o_rqa_rdy);
    end else begin
      i_rqa = {rnw, txn, addr};
      i_rqa_wr = 1'b1;
      tick();
      i_rqa_wr = 1'b0;
    end
  endtask

  task automatic push_rqd(input logic [7:0] ben, input logic [63:0] data);
    int n = 0;
    while (!o_rqd_rdy && n < 200) begin
      tick();
      n++;
    end
    n_vec++;
    if (!o_rqd_rdy) begin
      n_err++;
      $display("FAIL rqd_push_wait: o_rqd_rdy=%b required 1 within 200 cycles", o_rqd_rdy);
    end else begin
      i_rqd = {ben, data};
      i_rqd_wr = 1'b1;
      tick();
      i_rqd_wr = 1'b0;
    end
  endtask

  task automatic do_write(input logic [5:0] txn, input logic [36:0] addr,
                          input logic [7:0] ben, input logic [63:0] data);
    push_rqd(ben, data);
    push_rqa(1'b0, txn, addr);
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_vec += 6;
    if (o_rqa_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rqa_rdy: got %b want 1", o_rqa_rdy); end
    if (o_rqd_rdy !== 1'b1) begin n_err++; $display("FAIL reset_rqd_rdy: got %b want 1", o_rqd_rdy); end
    if (o_rss_vld !== 1'b0) begin n_err++; $display("FAIL reset_rss_vld: got %b want 0", o_rss_vld); end
    if (o_rss !== 9'h0) begin n_err++; $display("FAIL reset_rss: got %h want 000", o_rss); end
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL reset_rsd_vld: got %b want 0", o_rsd_vld); end
    if (o_rsd !== 64'h0) begin n_err++; $display("FAIL reset_rsd: got %h want 0", o_rsd); end
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    i_rss_rd = 1'b0;
    i_rsd_rd = 1'b0;
    do_write(6'h01, 37'd5, 8'hFF, 64'h1122334455667788);
    repeat (5) tick();
    n_vec += 3;
    if (o_rss_vld !== 1'b1) begin n_err++; $display("FAIL sr_wr_rss_vld: got %b want 1", o_rss_vld); end
    if (o_rss !== rss_exp(6'h01, 1'b0, 1'b0))
      begin n_err++; $display("FAIL sr_wr_rss: got %h want %h", o_rss, rss_exp(6'h01, 1'b0, 1'b0)); end
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL sr_wr_rsd_vld: got %b want 0", o_rsd_vld); end
    i_rss_rd = 1'b1;
    tick();
    i_rss_rd = 1'b0;
    n_vec++;
    if (o_rss_vld !== 1'b0) begin n_err++; $display("FAIL sr_rss_empty: got %b want 0", o_rss_vld); end
    push_rqa(1'b1, 6'h02, 37'd5);
    @(negedge clk);
    n_vec++;
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL sr_lat_c1: o_rsd_vld=%b want 0", o_rsd_vld); end
    @(negedge clk);
    n_vec++;
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL sr_lat_c2: o_rsd_vld=%b want 0", o_rsd_vld); end
    @(negedge clk);
    n_vec += 4;
    if (o_rsd_vld !== 1'b1) begin n_err++; $display("FAIL sr_lat_c3: o_rsd_vld=%b want 1", o_rsd_vld); end
    if (o_rss_vld !== 1'b1) begin n_err++; $display("FAIL sr_rd_rss_vld: got %b want 1", o_rss_vld); end
    if (o_rsd !== 64'h1122334455667788)
      begin n_err++; $display("FAIL sr_rd_rsd: got %h want 1122334455667788", o_rsd); end
    if (o_rss !== rss_exp(6'h02, 1'b1, 1'b0))
      begin n_err++; $display("FAIL sr_rd_rss: got %h want %h", o_rss, rss_exp(6'h02, 1'b1, 1'b0)); end
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    tick();
    i_rss_rd = 1'b0;
    i_rsd_rd = 1'b0;
    n_vec += 2;
    if (o_rss_vld !== 1'b0) begin n_err++; $display("FAIL sr_pop_rss_vld: got %b want 0", o_rss_vld); end
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL sr_pop_rsd_vld: got %b want 0", o_rsd_vld); end
  endtask

  task automatic test_byte_enables();
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    rss_q.delete();
    rsd_q.delete();
    do_write(6'h03, 37'd7, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
    do_write(6'h04, 37'd7, 8'h0F, 64'h0);
    push_rqa(1'b1, 6'h05, 37'd7);
    repeat (8) tick();
    n_vec += 2;
    if (rss_q.size() != 3) begin n_err++; $display("FAIL be_rss_count: got %0d want 3", rss_q.size()); end
    if (rsd_q.size() != 1) begin n_err++; $display("FAIL be_rsd_count: got %0d want 1", rsd_q.size()); end
    else begin
      n_vec++;
      if (rsd_q[0] !== 64'hFFFF_FFFF_0000_0000)
        begin n_err++; $display("FAIL be_rsd: got %h want ffffffff00000000", rsd_q[0]); end
    end
  endtask

  task automatic test_decoupled();
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    rss_q.delete();
    rsd_q.delete();
    push_rqa(1'b0, 6'h06, 37'd9);
    push_rqa(1'b1, 6'h07, 37'd9);
    repeat (10) tick();
    n_vec++;
    if (rss_q.size() != 0) begin n_err++; $display("FAIL dc_early_rsp: got %0d responses want 0", rss_q.size()); end
    push_rqd(8'hFF, 64'hDEAD_BEEF_0123_4567);
    repeat (6) tick();
    n_vec += 2;
    if (rss_q.size() != 2) begin n_err++; $display("FAIL dc_rss_count: got %0d want 2", rss_q.size()); end
    else begin
      n_vec += 2;
      if (rss_q[0] !== rss_exp(6'h06, 1'b0, 1'b0))
        begin n_err++; $display("FAIL dc_rss0: got %h want %h", rss_q[0], rss_exp(6'h06, 1'b0, 1'b0)); end
      if (rss_q[1] !== rss_exp(6'h07, 1'b1, 1'b0))
        begin n_err++; $display("FAIL dc_rss1: got %h want %h", rss_q[1], rss_exp(6'h07, 1'b1, 1'b0)); end
    end
    if (rsd_q.size() != 1) begin n_err++; $display("FAIL dc_rsd_count: got %0d want 1", rsd_q.size()); end
    else begin
      n_vec++;
      if (rsd_q[0] !== 64'hDEAD_BEEF_0123_4567)
        begin n_err++; $display("FAIL dc_rsd: got %h want deadbeef01234567", rsd_q[0]); end
    end
  endtask

  task automatic test_range_error();
    logic [8:0]  ers [5];
    logic [63:0] erd [3];
    ers[0] = rss_exp(6'h0B, 1'b0, 1'b0);
    ers[1] = rss_exp(6'h08, 1'b1, 1'b1);
    ers[2] = rss_exp(6'h09, 1'b0, 1'b1);
    ers[3] = rss_exp(6'h0A, 1'b1, 1'b0);
    ers[4] = rss_exp(6'h0C, 1'b1, 1'b0);
    erd[0] = 64'h0;
    erd[1] = 64'h0A0A_0A0A_0A0A_0A0A;
    erd[2] = 64'h1122334455667788;
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    rss_q.delete();
    rsd_q.delete();
    do_write(6'h0B, 37'd0, 8'hFF, 64'h0A0A_0A0A_0A0A_0A0A);
    push_rqa(1'b1, 6'h08, 37'h1000);
    do_write(6'h09, 37'h1000, 8'hFF, 64'h5555_5555_5555_5555);
    push_rqa(1'b1, 6'h0A, 37'd0);
    push_rqa(1'b1, 6'h0C, 37'd5);
    repeat (10) tick();
    n_vec += 3;
    if (rss_q.size() != 5) begin n_err++; $display("FAIL re_rss_count: got %0d want 5", rss_q.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        n_vec++;
        if (rss_q[i] !== ers[i]) begin n_err++; $display("FAIL re_rss%0d: got %h want %h", i, rss_q[i], ers[i]); end
      end
    end
    if (rsd_q.size() != 3) begin n_err++; $display("FAIL re_rsd_count: got %0d want 3", rsd_q.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (rsd_q[i] !== erd[i]) begin n_err++; $display("FAIL re_rsd%0d: got %h want %h", i, rsd_q[i], erd[i]); end
      end
    end
    if (o_rqd_rdy !== 1'b1) begin n_err++; $display("FAIL re_rqd_rdy: got %b want 1", o_rqd_rdy); end
  endtask

  task automatic test_back_to_back();
    int pushed = 0;
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bp_data[i] = 64'hC0DE_0000_0000_0000 | (64'(i) * 64'h0000_0001_0001_0001);
      do_write(6'h3F, 37'(100 + i), 8'hFF, bp_data[i]);
    end
    repeat (6) tick();
    rss_q.delete();
    rsd_q.delete();
    i_rss_rd = 1'b0;
    i_rsd_rd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (o_rqa_rdy && pushed < 20) begin
        i_rqa = {1'b1, 6'(pushed), 37'(100 + pushed)};
        i_rqa_wr = 1'b1;
        pushed++;
      end else begin
        i_rqa_wr = 1'b0;
      end
      tick();
    end
    i_rqa_wr = 1'b0;
    n_vec += 4;
    if (pushed != 8) begin n_err++; $display("FAIL bp_accepted: got %0d want 8", pushed); end
    if (o_rqa_rdy !== 1'b0) begin n_err++; $display("FAIL bp_rqa_rdy: got %b want 0", o_rqa_rdy); end
    if (o_rss_vld !== 1'b1) begin n_err++; $display("FAIL bp_rss_vld: got %b want 1", o_rss_vld); end
    if (o_rsd_vld !== 1'b1) begin n_err++; $display("FAIL bp_rsd_vld: got %b want 1", o_rsd_vld); end
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    while (pushed < 20) begin
      push_rqa(1'b1, 6'(pushed), 37'(100 + pushed));
      pushed++;
    end
    repeat (20) tick();
    n_vec += 2;
    if (rss_q.size() != 20) begin n_err++; $display("FAIL bp_rss_count: got %0d want 20", rss_q.size()); end
    if (rsd_q.size() != 20) begin n_err++; $display("FAIL bp_rsd_count: got %0d want 20", rsd_q.size()); end
    if (rss_q.size() == 20 && rsd_q.size() == 20) begin
      for (int i = 0; i < 20; i++) begin
        n_vec += 2;
        if (rss_q[i] !== rss_exp(6'(i), 1'b1, 1'b0))
          begin n_err++; $display("FAIL bp_rss%0d: got %h want %h", i, rss_q[i], rss_exp(6'(i), 1'b1, 1'b0)); end
        if (rsd_q[i] !== bp_data[i])
          begin n_err++; $display("FAIL bp_rsd%0d: got %h want %h", i, rsd_q[i], bp_data[i]); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    i_rss_rd = 1'b0;
    i_rsd_rd = 1'b0;
    push_rqa(1'b1, 6'h30, 37'd100);
    push_rqa(1'b1, 6'h31, 37'd101);
    push_rqa(1'b1, 6'h32, 37'd102);
    nrst = 1'b0;
    #1;
    n_vec += 4;
    if (o_rss_vld !== 1'b0) begin n_err++; $display("FAIL rm_rss_vld: got %b want 0", o_rss_vld); end
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL rm_rsd_vld: got %b want 0", o_rsd_vld); end
    if (o_rqa_rdy !== 1'b1) begin n_err++; $display("FAIL rm_rqa_rdy: got %b want 1", o_rqa_rdy); end
    if (o_rqd_rdy !== 1'b1) begin n_err++; $display("FAIL rm_rqd_rdy: got %b want 1", o_rqd_rdy); end
    tick();
    nrst = 1'b1;
    repeat (4) tick();
    n_vec += 2;
    if (o_rss_vld !== 1'b0) begin n_err++; $display("FAIL rm_post_rss_vld: got %b want 0", o_rss_vld); end
    if (o_rsd_vld !== 1'b0) begin n_err++; $display("FAIL rm_post_rsd_vld: got %b want 0", o_rsd_vld); end
    rss_q.delete();
    rsd_q.delete();
    i_rss_rd = 1'b1;
    i_rsd_rd = 1'b1;
    push_rqa(1'b1, 6'h21, 37'd101);
    repeat (6) tick();
    n_vec += 2;
    if (rss_q.size() != 1) begin n_err++; $display("FAIL rm_rss_count: got %0d want 1", rss_q.size()); end
    else begin
      n_vec++;
      if (rss_q[0] !== rss_exp(6'h21, 1'b1, 1'b0))
        begin n_err++; $display("FAIL rm_rss: got %h want %h", rss_q[0], rss_exp(6'h21, 1'b1, 1'b0)); end
    end
    if (rsd_q.size() != 1) begin n_err++; $display("FAIL rm_rsd_count: got %0d want 1", rsd_q.size()); end
    else begin
      n_vec++;
      if (rsd_q[0] !== bp_data[1])
        begin n_err++; $display("FAIL rm_rsd: got %h want %h", rsd_q[0], bp_data[1]); end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_byte_enables();
    test_decoupled();
    test_range_error();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
